// File: rtl/multiboot_request_scheduler.sv
// multiboot_request_scheduler
//   Takes reboot requests from several sources and arbitrates them by fixed
//   priority (index 0 highest). For each winner it computes the SPI flash
//   bitstream address, holds it stable for a settle window, then fires a
//   single-cycle ICAP reboot strobe. A lockout window follows each strobe.
// Ports:
//   clk_icap       : clock
//   reset_i        : asynchronous active-high reset
//   req_i          : per-source request level (rising edge = request)
//   req_core_x_i   : per-source select, 1 = core slot, 0 = default bitstream
//   req_core_id_i  : per-source 5-bit core id, source i at [5i+4:5i]
//   ack_o          : one-cycle grant pulse to the winner
//   grant_idx_o    : index of the last granted source
//   busy_o         : high whenever not idle
//   spi_addr_o     : flash address for the ICAP sequencer
//   mbt_reboot_o   : one-cycle reboot strobe
module multiboot_request_scheduler #(
  parameter int          NREQ         = 3,
  parameter logic [11:0] DEFAULT_PAGE = 12'h0B0,
  parameter logic [11:0] CORE_STRIDE  = 12'h0C4,
  parameter logic [11:0] CORE_OFFSET  = 12'h014,
  parameter int          MAX_CORE     = 20,
  parameter int          HOLD_CYCLES  = 16,
  parameter int          SEQ_CYCLES   = 32,
  localparam int         GW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk_icap,
  input  logic              reset_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   req_core_x_i,
  input  logic [5*NREQ-1:0] req_core_id_i,
  output logic [NREQ-1:0]   ack_o,
  output logic [GW-1:0]     grant_idx_o,
  output logic              busy_o,
  output logic [23:0]       spi_addr_o,
  output logic              mbt_reboot_o
);

  localparam int CMAX = (HOLD_CYCLES > SEQ_CYCLES) ? HOLD_CYCLES : SEQ_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_FIRE, S_WAIT} state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_req_prev;
  logic [NREQ-1:0]   r_pend;
  logic [CW-1:0]     r_cnt;
  logic [NREQ-1:0]   r_ack;
  logic [GW-1:0]     r_gidx;
  logic              r_busy;
  logic [23:0]       r_addr;
  logic              r_reboot;

  logic [NREQ-1:0]   w_rise;
  logic [NREQ-1:0]   w_clr;
  logic              w_any;
  logic [GW-1:0]     w_g;
  logic [4:0]        w_id;
  logic              w_cx;
  logic [11:0]       w_page;

  assign w_rise = req_i & ~r_req_prev;
  assign w_any  = |r_pend;

  // Lowest set pending index wins; scanning downward leaves the lowest last.
  always_comb begin
    w_g = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (r_pend[i]) w_g = GW'(i);
  end

  assign w_id = req_core_id_i[w_g*5 +: 5];
  assign w_cx = req_core_x_i[w_g];

  // Page math wraps in 12 bits on purpose: slot pages are mod 4096.
  always_comb begin
    w_page = DEFAULT_PAGE;
    if (w_cx && (w_id != 5'd0) && (int'(w_id) <= MAX_CORE))
      w_page = (CORE_STRIDE * {7'd0, w_id}) - CORE_OFFSET;
  end

  always_comb begin
    w_clr = '0;
    if (r_state == S_IDLE && w_any) w_clr[w_g] = 1'b1;
  end

  always_ff @(posedge clk_icap or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_req_prev <= '0;
      r_pend     <= '0;
      r_cnt      <= '0;
      r_ack      <= '0;
      r_gidx     <= '0;
      r_busy     <= 1'b0;
      r_addr     <= {DEFAULT_PAGE, 12'h000};
      r_reboot   <= 1'b0;
    end else begin
      r_req_prev <= req_i;
      // A new edge on the source being granted this cycle survives the clear.
      r_pend     <= (r_pend & ~w_clr) | w_rise;
      r_ack      <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_addr       <= {w_page, 12'h000};
            r_ack[w_g]   <= 1'b1;
            r_gidx       <= w_g;
            r_cnt        <= CW'(HOLD_CYCLES - 1);
            r_busy       <= 1'b1;
            r_state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_reboot <= 1'b1;
            r_state  <= S_FIRE;
          end
        end
        S_FIRE: begin
          r_reboot <= 1'b0;
          r_cnt    <= CW'(SEQ_CYCLES - 1);
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
          else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack_o        = r_ack;
  assign grant_idx_o  = r_gidx;
  assign busy_o       = r_busy;
  assign spi_addr_o   = r_addr;
  assign mbt_reboot_o = r_reboot;

endmodule

// File: doc/multiboot_request_scheduler.md
# multiboot_request_scheduler

Sequences FPGA reconfiguration requests for the Spartan-6 ICAP multiboot sequencer. It accepts reboot requests from several independent sources (hotkey, NextREG write, core-select menu) and arbitrates them by fixed priority. For the winning request it computes the SPI flash bitstream address, holds that address stable for a settle window, then issues a single-cycle reboot strobe. After the strobe it blocks further strobes for the duration of the ICAP command sequence.

## Interface
Parameters:
- `NREQ`, 3: number of requesters; index 0 has the highest priority.
- `DEFAULT_PAGE`, 12'h0B0: 4 KB page of the default (Next) bitstream.
- `CORE_STRIDE`, 12'h0C4: page stride between core slots.
- `CORE_OFFSET`, 12'h014: subtracted after the multiply.
- `MAX_CORE`, 20: highest valid core id.
- `HOLD_CYCLES`, 16: settle cycles between address update and strobe; must be ≥1.
- `SEQ_CYCLES`, 32: lockout cycles after the strobe; must be ≥1.

Ports:
- `clk_icap`, in, 1: the single clock.
- `reset_i`, in, 1: asynchronous, active-high reset.
- `req_i`, in, NREQ: per-source request level; only rising edges count.
- `req_core_x_i`, in, NREQ: per-source select; 1 = core slot, 0 = default bitstream.
- `req_core_id_i`, in, 5*NREQ: per-source core id; bits [5i+4:5i] belong to source i.
- `ack_o`, out, NREQ: one-cycle grant pulse to the winning source.
- `grant_idx_o`, out, $clog2(NREQ) (min 1): index of the last granted source.
- `busy_o`, out, 1: high in every state except IDLE.
- `spi_addr_o`, out, 24: flash address for the ICAP sequencer.
- `mbt_reboot_o`, out, 1: one-cycle reboot strobe.

## Operation
- Edge detection: `req_prev` registers `req_i`. When `req_i[i]` is 1 and `req_prev[i]` is 0 at a clock edge, `pending[i]` is set. Levels held high produce no further requests.
- `pending` bits are recorded in every state, so requests that arrive while busy are served later.
- States: IDLE, SETTLE, FIRE, WAIT.
- IDLE, when `pending` is nonzero:
  - Select the lowest set index g.
  - Load `spi_addr_o`, set `ack_o[g]` and `grant_idx_o`=g.
  - Clear `pending[g]`, load `cnt`=HOLD_CYCLES-1, go to SETTLE.
- SETTLE:
  - `cnt`≠0: decrement `cnt`.
  - `cnt`=0: set `mbt_reboot_o`, go to FIRE.
- FIRE: clear `mbt_reboot_o`, load `cnt`=SEQ_CYCLES-1, go to WAIT.
- WAIT:
  - `cnt`≠0: decrement `cnt`.
  - `cnt`=0: go to IDLE.
- Address rule:
  - `spi_addr_o[11:0]` is always 0.
  - If `req_core_x_i[g]`=0, or id=0, or id>MAX_CORE: `[23:12]`=DEFAULT_PAGE.
  - Otherwise: `[23:12]`=(CORE_STRIDE*id − CORE_OFFSET) mod 2^12, computed in 12-bit arithmetic.
  - With the defaults: id 1 → 0x0B0000, id 2 → 0x174000, id 20 → 0xF3C000.
- `spi_addr_o` changes only on a grant. Between grants it is stable, including through SETTLE, FIRE and WAIT.
- Simultaneous events:
  - Several edges in the same cycle: all are recorded; they are granted one per pass, lowest index first.
  - New edge on index g in the same cycle g is granted: the set wins, so g stays pending and is served again.
- Reset (`reset_i` high, asynchronous, also mid-sequence):
  - state=IDLE, `pending`=0, `req_prev`=0, `cnt`=0.
  - `ack_o`=0, `grant_idx_o`=0, `busy_o`=0, `mbt_reboot_o`=0, `spi_addr_o`={DEFAULT_PAGE,12'h000}=0x0B0000.
  - No strobe is emitted during or after reset. Because `req_prev` is cleared, a `req_i` level still high at reset release counts as an edge.

## Timing
- Let E0 be the edge that samples the rising edge of `req_i[i]`; `pending[i]` is set at E0.
- E1 (only if IDLE at E0): grant. From E1, `ack_o` is high for exactly one cycle, `spi_addr_o` holds the new value and `busy_o`=1.
- E(HOLD_CYCLES+1): `mbt_reboot_o` rises and stays high for exactly one cycle. With the defaults this is E17.
- E(HOLD_CYCLES+2): FIRE is left and WAIT begins.
- E(HOLD_CYCLES+SEQ_CYCLES+2): IDLE is reached and `busy_o` falls. The earliest next grant is the following edge.
- Strobe spacing: the minimum gap between two `mbt_reboot_o` pulses is HOLD_CYCLES+SEQ_CYCLES+2 cycles.
- All outputs are registered; no combinational path exists from inputs to outputs.

## Test plan
- Reset, then pulse `req_i[2]` with `req_core_x_i[2]`=0 → `ack_o[2]` high at E1, `spi_addr_o`=0x0B0000, `mbt_reboot_o` high for one cycle at E17, `busy_o` low at E50.
- Rising edge on `req_i[1]` with core_x=1, id=2 → `spi_addr_o`=0x174000. Repeat with id=20 → 0xF3C000. Repeat with id=0 and id=25 → 0x0B0000 each time.
- Raise `req_i[0]` and `req_i[2]` in the same cycle → source 0 is granted first. Source 2 is granted on the edge after `busy_o` falls. Exactly two strobes occur, spaced 50 cycles apart.
- Hold `req_i[1]` high for 200 cycles → exactly one grant and one strobe.
- Assert `reset_i` for one cycle during SETTLE → all outputs return to reset values immediately and no strobe follows. Then:
  - If `req_i` is still high at release: one fresh grant.
  - Otherwise: no grant.
- Give source 1 a new edge in the same cycle it is granted → a second grant of source 1 follows the WAIT period.
